dds_cmd_sequencer: RTL and testbench

- Byte-level command sequencer between the UART receive/transmit interface and the DDS configuration inputs (en, m, set).
- Parses single-byte opcodes with an optional 4-byte payload.
- Applies enable, disable and tuning-word updates to the DDS.
- Returns an acknowledge byte or a status frame on the UART transmit side, with an inter-byte timeout that aborts partial frames.

---
 rtl/dds_cmd_pkg.sv | 51 +++++
 rtl/dds_reply_tx.sv | 90 +++++++++
 rtl/dds_cmd_sequencer.sv | 137 +++++++++++++
 tb/tb_dds_cmd_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dds_cmd_pkg.sv
// Shared opcodes, responses, FSM encodings and reply-queue payload for the DDS command sequencer.
package dds_cmd_pkg;

    localparam int unsigned STATUS_LEN = 5;
    localparam int unsigned LEN_W      = 3;

    localparam logic [7:0] OP_FREQ = 8'h46;
    localparam logic [7:0] OP_EN   = 8'h45;
    localparam logic [7:0] OP_DIS  = 8'h44;
    localparam logic [7:0] OP_STAT = 8'h53;

    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_NAK = 8'h4E;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_APPLY,
        ST_REPLY
    } state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_WAIT,
        TX_PULSE,
        TX_HOLD,
        TX_DRAIN
    } tx_state_t;

    // Byte 0 of data is transmitted first.
    typedef struct packed {
        logic [LEN_W-1:0]                 len;
        logic [STATUS_LEN-1:0][7:0]       data;
    } reply_t;

    function automatic reply_t one_byte(input logic [7:0] b);
        reply_t r;
        r         = '0;
        r.len     = LEN_W'(1);
        r.data[0] = b;
        return r;
    endfunction

    function automatic reply_t status_frame(input logic en_v, input logic [31:0] m_v);
        reply_t r;
        r.len  = LEN_W'(STATUS_LEN);
        r.data = {m_v[7:0], m_v[15:8], m_v[23:16], m_v[31:24], {7'b0, en_v}};
        return r;
    endfunction

endpackage

// File: rtl/dds_reply_tx.sv
// Sends a queued reply of 1..5 bytes through the UART transmit handshake.
module dds_reply_tx
    import dds_cmd_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [LEN_W-1:0]           len,
    input  logic [STATUS_LEN-1:0][7:0] data,
    input  logic                       is_transmitting,
    output logic                       transmit,
    output logic [7:0]                 tx_byte,
    output logic                       done
);

    tx_state_t                  state, state_nx;
    logic [LEN_W-1:0]           idx, idx_nx;
    logic [LEN_W-1:0]           len_q, len_nx;
    logic [STATUS_LEN-1:0][7:0] data_q, data_nx;
    logic                       transmit_nx;
    logic [7:0]                 tx_byte_nx;
    logic                       done_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= TX_IDLE;
            idx      <= '0;
            len_q    <= '0;
            data_q   <= '0;
            transmit <= 1'b0;
            tx_byte  <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            len_q    <= len_nx;
            data_q   <= data_nx;
            transmit <= transmit_nx;
            tx_byte  <= tx_byte_nx;
            done     <= done_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        len_nx      = len_q;
        data_nx     = data_q;
        transmit_nx = 1'b0;
        tx_byte_nx  = tx_byte;
        done_nx     = 1'b0;
        case (state)
            TX_IDLE: begin
                if (start) begin
                    idx_nx  = '0;
                    len_nx  = len;
                    data_nx = data;
                    if (len == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        state_nx = TX_WAIT;
                    end
                end
            end
            TX_WAIT: begin
                if (!is_transmitting) begin
                    transmit_nx = 1'b1;
                    tx_byte_nx  = data_q[idx];
                    state_nx    = TX_PULSE;
                end
            end
            TX_PULSE: state_nx = TX_HOLD;
            // Give the UART a cycle to raise busy before sampling it again.
            TX_HOLD:  state_nx = TX_DRAIN;
            TX_DRAIN: begin
                if (!is_transmitting) begin
                    if (idx == len_q - LEN_W'(1)) begin
                        done_nx  = 1'b1;
                        state_nx = TX_IDLE;
                    end else begin
                        idx_nx   = idx + LEN_W'(1);
                        state_nx = TX_WAIT;
                    end
                end
            end
            default: state_nx = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/dds_cmd_sequencer.sv
// UART byte command parser driving the DDS enable, tuning word and load strobe,
// with acknowledge/status replies and an inter-byte payload timeout.
module dds_cmd_sequencer
    import dds_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1200000,
    parameter int unsigned TO_W           = 21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        received,
    input  logic [7:0]  rx_byte,
    input  logic        is_transmitting,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    output logic        en,
    output logic [31:0] m,
    output logic        set
);

    state_t          state, state_nx;
    logic [1:0]      idx, idx_nx;
    logic [TO_W-1:0] to_cnt, to_cnt_nx;
    logic [31:0]     shadow, shadow_nx;
    logic [31:0]     m_nx;
    logic            en_nx;
    logic            set_nx;
    logic            start, start_nx;
    reply_t          reply, reply_nx;
    logic            tx_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            to_cnt <= '0;
            shadow <= '0;
            en     <= 1'b0;
            m      <= '0;
            set    <= 1'b0;
            start  <= 1'b0;
            reply  <= '0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            to_cnt <= to_cnt_nx;
            shadow <= shadow_nx;
            en     <= en_nx;
            m      <= m_nx;
            set    <= set_nx;
            start  <= start_nx;
            reply  <= reply_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        to_cnt_nx = to_cnt;
        shadow_nx = shadow;
        en_nx     = en;
        m_nx      = m;
        set_nx    = 1'b0;
        start_nx  = 1'b0;
        reply_nx  = reply;
        case (state)
            ST_IDLE: begin
                if (received) begin
                    state_nx = ST_REPLY;
                    start_nx = 1'b1;
                    case (rx_byte)
                        OP_FREQ: begin
                            idx_nx    = '0;
                            to_cnt_nx = '0;
                            state_nx  = ST_PAYLOAD;
                            start_nx  = 1'b0;
                        end
                        OP_EN: begin
                            en_nx    = 1'b1;
                            reply_nx = one_byte(RSP_ACK);
                        end
                        OP_DIS: begin
                            en_nx    = 1'b0;
                            reply_nx = one_byte(RSP_ACK);
                        end
                        OP_STAT: reply_nx = status_frame(en, m);
                        default: reply_nx = one_byte(RSP_NAK);
                    endcase
                end
            end
            ST_PAYLOAD: begin
                // A byte in the expiry cycle wins over the timeout.
                if (received) begin
                    shadow_nx = {shadow[23:0], rx_byte};
                    idx_nx    = idx + 2'd1;
                    to_cnt_nx = '0;
                    if (idx == 2'd3) begin
                        m_nx     = shadow_nx;
                        set_nx   = 1'b1;
                        state_nx = ST_APPLY;
                    end
                end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    shadow_nx = '0;
                    reply_nx  = one_byte(RSP_NAK);
                    start_nx  = 1'b1;
                    state_nx  = ST_REPLY;
                end else begin
                    to_cnt_nx = to_cnt + TO_W'(1);
                end
            end
            ST_APPLY: begin
                reply_nx = one_byte(RSP_ACK);
                start_nx = 1'b1;
                state_nx = ST_REPLY;
            end
            ST_REPLY: begin
                if (tx_done) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    dds_reply_tx u_reply_tx (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .len             (reply.len),
        .data            (reply.data),
        .is_transmitting (is_transmitting),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .done            (tx_done)
    );

endmodule

// File: tb/tb_dds_cmd_sequencer.sv
// Directed self-checking bench for dds_cmd_sequencer with a 10-cycle-busy UART model.
module tb_dds_cmd_sequencer;

    localparam int unsigned TO_CYC = 16;
    localparam int unsigned TO_W   = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        received;
    logic [7:0]  rx_byte;
    logic        is_transmitting;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic        en;
    logic [31:0] m;
    logic        set;

    int total = 0;
    int bad   = 0;

    int         busy_cnt = 0;
    logic [7:0] tx_q[$];
    logic [7:0] held = 8'h00;
    int         set_cnt = 0;
    int         hold_err = 0;
    int         overlap_err = 0;
    logic [7:0] exp_s[5];

    dds_cmd_sequencer #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(TO_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .received        (received),
        .rx_byte         (rx_byte),
        .is_transmitting (is_transmitting),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .en              (en),
        .m               (m),
        .set             (set)
    );

    always #5 clk = ~clk;

    assign is_transmitting = (busy_cnt != 0);

    // UART model: busy for 10 cycles after each transmit pulse.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= 0;
        end else begin
            if (transmit && busy_cnt != 0) overlap_err++;
            if (busy_cnt != 0 && tx_byte !== held) hold_err++;
            if (set) set_cnt++;
            if (transmit) begin
                busy_cnt <= 10;
                held     <= tx_byte;
                tx_q.push_back(tx_byte);
            end else if (busy_cnt != 0) begin
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        received = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        received = 1'b0;
    endtask

    task automatic wait_reply(input string tag, input int n);
        int k;
        k = 0;
        while (tx_q.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (is_transmitting && k < 100) begin
            @(negedge clk);
            k++;
        end
        repeat (6) @(negedge clk);
        chk(tag, 32'(tx_q.size()), 32'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        received = 1'b0;
        rx_byte  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst en", 32'(en), 32'h0);
        chk("rst m", m, 32'h0);
        chk("rst set", 32'(set), 32'h0);
        chk("rst transmit", 32'(transmit), 32'h0);
        chk("rst tx_byte", 32'(tx_byte), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Enable
        tx_q.delete();
        send(8'h45);
        chk("E en", 32'(en), 32'h1);
        wait_reply("E tx count", 1);
        chk("E ack", 32'(tx_q[0]), 32'h4B);
        chk("E no set", 32'(set_cnt), 32'h0);

        // Frequency load
        tx_q.delete();
        send(8'h46);
        send(8'h01);
        send(8'h23);
        send(8'h45);
        chk("F set before 4th", 32'(set), 32'h0);
        send(8'h67);
        chk("F set pulse", 32'(set), 32'h1);
        chk("F m", m, 32'h01234567);
        @(negedge clk);
        chk("F set drop", 32'(set), 32'h0);
        wait_reply("F tx count", 1);
        chk("F ack", 32'(tx_q[0]), 32'h4B);
        chk("F set count", 32'(set_cnt), 32'h1);
        chk("F en kept", 32'(en), 32'h1);

        // Status
        exp_s = '{8'h01, 8'h01, 8'h23, 8'h45, 8'h67};
        tx_q.delete();
        send(8'h53);
        wait_reply("S tx count", 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("S byte%0d", i), 32'(tx_q[i]), 32'(exp_s[i]));
        end

        // Payload timeout
        tx_q.delete();
        send(8'h46);
        send(8'hAA);
        send(8'hBB);
        wait_reply("TO tx count", 1);
        chk("TO nak", 32'(tx_q[0]), 32'h4E);
        chk("TO m kept", m, 32'h01234567);
        chk("TO no set", 32'(set_cnt), 32'h1);
        tx_q.delete();
        send(8'h53);
        wait_reply("TO S tx count", 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("TO S byte%0d", i), 32'(tx_q[i]), 32'(exp_s[i]));
        end

        // Unknown opcode; a 'D' during the reply must be dropped
        tx_q.delete();
        send(8'h7A);
        send(8'h44);
        wait_reply("NAK tx count", 1);
        chk("NAK byte", 32'(tx_q[0]), 32'h4E);
        chk("NAK en kept", 32'(en), 32'h1);
        chk("NAK m kept", m, 32'h01234567);

        // Reset mid-payload
        send(8'h46);
        send(8'h11);
        send(8'h22);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid rst en", 32'(en), 32'h0);
        chk("mid rst m", m, 32'h0);
        chk("mid rst set", 32'(set), 32'h0);
        chk("mid rst transmit", 32'(transmit), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tx_q.delete();
        send(8'h46);
        send(8'hDE);
        send(8'hAD);
        send(8'hBE);
        send(8'hEF);
        chk("post rst set", 32'(set), 32'h1);
        chk("post rst m", m, 32'hDEADBEEF);
        wait_reply("post rst tx count", 1);
        chk("post rst ack", 32'(tx_q[0]), 32'h4B);
        chk("post rst en", 32'(en), 32'h0);

        chk("tx while busy", 32'(overlap_err), 32'h0);
        chk("tx_byte held", 32'(hold_err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
